fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline; it sits directly upstream of the IF/ID register and decode, and consumes the call sequencer's injected opcodes, stall and PC-redirect signals. It owns the 32-bit PC, loads the reset vector from instruction memory, assembles 32-bit (two-word) instructions, and arbitrates between normal fetch, call-sequencer injection, hazard stalls and control-flow redirects. Its outputs form the IF/ID pipeline register.

## Interface
- ADDR_W, 20, instruction-memory word-address width
- IMM_MASK, 16'hE000, opcode bits tested for a two-word instruction
- IMM_MATCH, 16'hA000, a word is two-word when (word & IMM_MASK) == IMM_MATCH

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- imem_addr  out  ADDR_W  word address, = pc[ADDR_W-1:0] or the vector address during reset load
- imem_data  in  16  combinational read data for imem_addr, same cycle
- inject_instr  in  16  opcode injected by the call sequencer, 0 = bubble
- inject_stall  in  1  call sequencer is active
- change_pc  in  1  call redirect strobe
- target_pc  in  32  call target
- branch_taken  in  1  redirect from execute
- branch_target  in  32  branch/jump/ret target
- hazard_stall  in  1  load-use stall from the hazard unit
- pc  out  32  current fetch PC
- if_id_instr  out  16  first (or only) instruction word
- if_id_imm  out  16  second word of a two-word instruction, else 0
- if_id_pc  out  32  address after the last word of the instruction (return address)
- if_id_valid  out  1  IF/ID holds a real instruction

## Operation
- States: RST_LO, RST_HI, RUN, IMM.
- Reset (reset==0 at posedge): state RST_LO; pc, if_id_instr, if_id_imm, if_id_pc, internal first-word latch = 0; if_id_valid = 0. Applies from any state, including mid-IMM; all other inputs are ignored.
- RST_LO: imem_addr = 0; pc[15:0] <= imem_data; -> RST_HI. RST_HI: imem_addr = 1; pc[31:16] <= imem_data; -> RUN. IF/ID holds a bubble in both states, and redirect/stall inputs are ignored.
- RUN/IMM priority per cycle, highest first:
  1. change_pc: pc <= target_pc; IF/ID <= bubble (all 0, valid 0); -> RUN.
  2. branch_taken: pc <= branch_target; IF/ID <= bubble; -> RUN. A half-assembled two-word instruction is discarded.
  3. hazard_stall: pc, state, first-word latch and all IF/ID outputs hold.
  4. inject_stall: pc holds; if_id_instr <= inject_instr; if_id_imm <= 0; if_id_pc <= pc; if_id_valid <= (inject_instr != 0). Injection in IMM is illegal (the call sequencer starts only after a decoded CALL); the state holds.
  5. Normal fetch, RUN: word = imem_data. If two-word: latch <= word; pc <= pc+1; IF/ID <= bubble; -> IMM. Else IF/ID <= {word, imm 0, pc+1, valid 1}; pc <= pc+1.
  6. Normal fetch, IMM: IF/ID <= {latch, imem_data, pc+1, valid 1}; pc <= pc+1; -> RUN.
- Arithmetic: pc+1 is modulo 2^32 (FFFF_FFFF -> 0). imem_addr truncates pc to ADDR_W bits, so addresses wrap silently.

## Timing
- All registers update on posedge clk. Only imem_addr is combinational (from pc/state).
- Reset release: vector load takes 2 cycles. The first instruction is visible on IF/ID after the 3rd posedge with reset high.
- One-word instruction: 1 cycle to IF/ID. Two-word instruction: 2 cycles; a bubble is issued in the first.
- Redirect: the target is fetched in the cycle after the strobe, and exactly one bubble is inserted.
- change_pc and branch_taken together: change_pc wins, and branch_target is dropped.
- hazard_stall with inject_stall: the hazard wins. The injected opcode is not consumed, because the call sequencer holds it while its own stall is high.
- Injected opcodes 0x6008 and 0x6009 appear on if_id_instr one cycle after they appear on inject_instr.

## Test plan
- Reset vector: M[0]=0x1234, M[1]=0x0000, M[0x1234]=0x0C00, release reset -> pc=0x00001234 after 2 cycles; if_id_instr=0x0C00, if_id_pc=0x1235, valid=1 after the 3rd.
- Two-word: pc=0x10, M[0x10]=0xA005, M[0x11]=0xBEEF -> bubble, then if_id_instr=0xA005, if_id_imm=0xBEEF, if_id_pc=0x12, pc=0x12.
- Call injection: pc=0x40, inject_stall=1 for 4 cycles with inject_instr 0x6008, 0x6009, 0, 0, then change_pc=1, target_pc=0x200 -> IF/ID shows 0x6008, 0x6009 (if_id_pc=0x40), two bubbles, one bubble, then the fetch at 0x200; pc held at 0x40 throughout the injection.
- Branch in IMM: two-word word 1 fetched at 0x20, then branch_taken=1, branch_target=0x80 -> bubble, no partial instruction issued, next valid instruction is from 0x80.
- Priority: change_pc, branch_taken, hazard_stall and inject_stall all high -> pc=target_pc and a bubble. hazard_stall+inject_stall -> IF/ID and pc frozen.
- Wrap / reset mid-op: pc=0xFFFFFFFF with a one-word instruction -> if_id_pc=0, pc=0. Assert reset while in IMM -> all outputs 0, state RST_LO next cycle.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Instruction-memory read port and IF/ID pipeline register bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic [15:0]       if_id_instr;
    logic [15:0]       if_id_imm;
    logic [31:0]       if_id_pc;
    logic              if_id_valid;

    // Fetch side: drives the memory address and the IF/ID register.
    modport master (
        output imem_addr,
        input  imem_data,
        output if_id_instr,
        output if_id_imm,
        output if_id_pc,
        output if_id_valid
    );

    // Memory/decode side.
    modport slave (
        input  imem_addr,
        output imem_data,
        input  if_id_instr,
        input  if_id_imm,
        input  if_id_pc,
        input  if_id_valid
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : PC owner, reset-vector loader and two-word instruction assembler.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int          ADDR_W    = 20,
    parameter logic [15:0] IMM_MASK  = 16'hE000,
    parameter logic [15:0] IMM_MATCH = 16'hA000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus,
    input  logic [15:0]   inject_instr,
    input  logic          inject_stall,
    input  logic          change_pc,
    input  logic [31:0]   target_pc,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          hazard_stall,
    output logic [31:0]   pc
);

    typedef enum logic [1:0] {
        RST_LO = 2'd0,
        RST_HI = 2'd1,
        RUN    = 2'd2,
        IMM    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_nxt;
    logic [15:0]       r_latch;
    logic [15:0]       w_latch_nxt;
    logic [15:0]       r_instr;
    logic [15:0]       w_instr_nxt;
    logic [15:0]       r_imm;
    logic [15:0]       w_imm_nxt;
    logic [31:0]       r_ifpc;
    logic [31:0]       w_ifpc_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [31:0]       w_pc_inc;
    logic              w_two_word;
    logic [ADDR_W-1:0] w_imem_addr;

    assign w_pc_inc   = r_pc + 32'd1;
    assign w_two_word = (bus.imem_data & IMM_MASK) == IMM_MATCH;

    // The vector words live at addresses 0 and 1 while the PC is being loaded.
    always_comb begin
        w_imem_addr = r_pc[ADDR_W-1:0];
        case (r_state)
            RST_LO:  w_imem_addr = '0;
            RST_HI:  w_imem_addr = ADDR_W'(1);
            default: w_imem_addr = r_pc[ADDR_W-1:0];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_latch_nxt = r_latch;
        w_instr_nxt = r_instr;
        w_imm_nxt   = r_imm;
        w_ifpc_nxt  = r_ifpc;
        w_valid_nxt = r_valid;

        case (r_state)
            RST_LO: begin
                w_pc_nxt    = {r_pc[31:16], bus.imem_data};
                w_instr_nxt = 16'h0;
                w_imm_nxt   = 16'h0;
                w_ifpc_nxt  = 32'h0;
                w_valid_nxt = 1'b0;
                w_state_nxt = RST_HI;
            end
            RST_HI: begin
                w_pc_nxt    = {bus.imem_data, r_pc[15:0]};
                w_instr_nxt = 16'h0;
                w_imm_nxt   = 16'h0;
                w_ifpc_nxt  = 32'h0;
                w_valid_nxt = 1'b0;
                w_state_nxt = RUN;
            end
            default: begin
                if (change_pc) begin
                    w_pc_nxt    = target_pc;
                    w_instr_nxt = 16'h0;
                    w_imm_nxt   = 16'h0;
                    w_ifpc_nxt  = 32'h0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = RUN;
                end else if (branch_taken) begin
                    // Returning to RUN drops any half-assembled two-word op.
                    w_pc_nxt    = branch_target;
                    w_instr_nxt = 16'h0;
                    w_imm_nxt   = 16'h0;
                    w_ifpc_nxt  = 32'h0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = RUN;
                end else if (hazard_stall) begin
                    w_state_nxt = r_state;
                end else if (inject_stall) begin
                    w_instr_nxt = inject_instr;
                    w_imm_nxt   = 16'h0;
                    w_ifpc_nxt  = r_pc;
                    w_valid_nxt = (inject_instr != 16'h0);
                end else if (r_state == IMM) begin
                    w_instr_nxt = r_latch;
                    w_imm_nxt   = bus.imem_data;
                    w_ifpc_nxt  = w_pc_inc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = RUN;
                end else if (w_two_word) begin
                    w_latch_nxt = bus.imem_data;
                    w_instr_nxt = 16'h0;
                    w_imm_nxt   = 16'h0;
                    w_ifpc_nxt  = 32'h0;
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = IMM;
                end else begin
                    w_instr_nxt = bus.imem_data;
                    w_imm_nxt   = 16'h0;
                    w_ifpc_nxt  = w_pc_inc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RST_LO;
            r_pc    <= 32'h0;
            r_latch <= 16'h0;
            r_instr <= 16'h0;
            r_imm   <= 16'h0;
            r_ifpc  <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_latch <= w_latch_nxt;
            r_instr <= w_instr_nxt;
            r_imm   <= w_imm_nxt;
            r_ifpc  <= w_ifpc_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.imem_addr   = w_imem_addr;
    assign bus.if_id_instr = r_instr;
    assign bus.if_id_imm   = r_imm;
    assign bus.if_id_pc    = r_ifpc;
    assign bus.if_id_valid = r_valid;
    assign pc              = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed vector table, stall-in-IMM sequence and random model run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int c_addr_w = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] inject_instr;
    logic        inject_stall;
    logic        change_pc;
    logic [31:0] target_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        hazard_stall;
    logic [31:0] pc;

    logic [15:0] mem [0:(1<<c_addr_w)-1];

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage_if #(.ADDR_W(c_addr_w)) bus ();

    assign bus.imem_data = mem[bus.imem_addr];

    fetch_stage #(.ADDR_W(c_addr_w)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .inject_instr  (inject_instr),
        .inject_stall  (inject_stall),
        .change_pc     (change_pc),
        .target_pc     (target_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hazard_stall  (hazard_stall),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        chg;
        logic [31:0] tgt;
        logic        br;
        logic [31:0] btgt;
        logic        haz;
        logic        inj_s;
        logic [15:0] inj;
        logic [31:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_imm;
        logic [31:0] e_ifpc;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic [31:0] t, logic b, logic [31:0] bt,
                                logic h, logic is, logic [15:0] ii, logic [31:0] ep,
                                logic [15:0] ei, logic [15:0] em, logic [31:0] ef, logic ev);
        vec_t v;
        v.rst_n = r;  v.chg = c;  v.tgt = t;  v.br = b;  v.btgt = bt;
        v.haz = h;    v.inj_s = is; v.inj = ii;
        v.e_pc = ep;  v.e_instr = ei; v.e_imm = em; v.e_ifpc = ef; v.e_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic [31:0] t, input logic b,
                         input logic [31:0] bt, input logic h, input logic is,
                         input logic [15:0] ii);
        reset = r; change_pc = c; target_pc = t; branch_taken = b; branch_target = bt;
        hazard_stall = h; inject_stall = is; inject_instr = ii;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ep, input logic [15:0] ei,
                           input logic [15:0] em, input logic [31:0] ef, input logic ev);
        chk({tag, " pc"},    pc,                     ep);
        chk({tag, " instr"}, {16'h0, bus.if_id_instr}, {16'h0, ei});
        chk({tag, " imm"},   {16'h0, bus.if_id_imm},   {16'h0, em});
        chk({tag, " ifpc"},  bus.if_id_pc,           ef);
        chk({tag, " valid"}, {31'h0, bus.if_id_valid}, {31'h0, ev});
    endtask

    // Reference model: remaining vector loads, pending first word, IF/ID contents.
    int          m_loads;
    bit          m_known = 1'b0;
    logic [15:0] m_pend[$];
    logic [31:0] m_pc, m_ifpc;
    logic [15:0] m_instr, m_imm;
    logic        m_valid;

    function automatic logic [15:0] rd(input logic [31:0] a);
        return mem[a[c_addr_w-1:0]];
    endfunction

    task automatic m_bubble();
        m_instr = 16'h0; m_imm = 16'h0; m_ifpc = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        if (!reset) begin
            m_known = 1'b1; m_loads = 2; m_pend.delete(); m_pc = 32'h0; m_bubble();
        end else if (m_loads == 2) begin
            m_pc[15:0] = rd(32'd0); m_loads = 1; m_bubble();
        end else if (m_loads == 1) begin
            m_pc[31:16] = rd(32'd1); m_loads = 0; m_bubble();
        end else if (change_pc) begin
            m_pc = target_pc; m_pend.delete(); m_bubble();
        end else if (branch_taken) begin
            m_pc = branch_target; m_pend.delete(); m_bubble();
        end else if (hazard_stall) begin
            m_pc = m_pc;
        end else if (inject_stall) begin
            m_instr = inject_instr; m_imm = 16'h0; m_ifpc = m_pc;
            m_valid = (inject_instr != 16'h0);
        end else if (m_pend.size() > 0) begin
            m_instr = m_pend.pop_front();
            m_imm   = rd(m_pc);
            m_pc    = m_pc + 32'd1;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
        end else begin
            w = rd(m_pc);
            m_pc = m_pc + 32'd1;
            if ((w & 16'hE000) == 16'hA000) begin
                m_pend.push_back(w); m_bubble();
            end else begin
                m_instr = w; m_imm = 16'h0; m_ifpc = m_pc; m_valid = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] pick_target();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 8)       return 32'($urandom_range(0, 4095));
        else if (sel == 8) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else               return $urandom;
    endfunction

    initial begin
        logic [31:0] exp_addr;
        int          sel;

        for (int a = 0; a < (1 << c_addr_w); a++) mem[a] = 16'h0;
        mem[0]       = 16'h1234;  mem[1]       = 16'h0000;
        mem[20'h1234] = 16'h0C00; mem[20'h1235] = 16'h0001;
        mem[20'h10]  = 16'hA005;  mem[20'h11]  = 16'hBEEF;  mem[20'h12] = 16'h0001;
        mem[20'h200] = 16'h1111;
        mem[20'h20]  = 16'hA0FF;  mem[20'h21]  = 16'h5555;
        mem[20'h80]  = 16'h2222;  mem[20'h300] = 16'h3333;
        mem[20'hFFFFF] = 16'h4444;
        mem[20'h500] = 16'hA123;  mem[20'h501] = 16'h7777;

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);

        //                 rst  chg tgt          br  btgt   haz  is  inj       pc           instr    imm      ifpc         v
        vecs.push_back(mk(1'b0, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h0,        16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b0, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h0,        16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 1, 32'h999,      1, 32'h9,  1,   1, 16'h6008, 32'h1234,     16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h1234,     16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h1235,     16'h0C00,16'h0,   32'h1235,    1));
        vecs.push_back(mk(1'b1, 0, 32'h0,        1, 32'h10, 0,   0, 16'h0,    32'h10,       16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h11,       16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h12,       16'hA005,16'hBEEF,32'h12,      1));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  1,   0, 16'h0,    32'h12,       16'hA005,16'hBEEF,32'h12,      1));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  1,   1, 16'h6008, 32'h12,       16'hA005,16'hBEEF,32'h12,      1));
        vecs.push_back(mk(1'b1, 1, 32'h40,       0, 32'h0,  0,   0, 16'h0,    32'h40,       16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   1, 16'h6008, 32'h40,       16'h6008,16'h0,   32'h40,      1));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   1, 16'h6009, 32'h40,       16'h6009,16'h0,   32'h40,      1));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   1, 16'h0,    32'h40,       16'h0,   16'h0,   32'h40,      0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   1, 16'h0,    32'h40,       16'h0,   16'h0,   32'h40,      0));
        vecs.push_back(mk(1'b1, 1, 32'h200,      0, 32'h0,  0,   0, 16'h0,    32'h200,      16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h201,      16'h1111,16'h0,   32'h201,     1));
        vecs.push_back(mk(1'b1, 0, 32'h0,        1, 32'h20, 0,   0, 16'h0,    32'h20,       16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h21,       16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        1, 32'h80, 0,   0, 16'h0,    32'h80,       16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h81,       16'h2222,16'h0,   32'h81,      1));
        vecs.push_back(mk(1'b1, 1, 32'h300,      1, 32'h400,1,   1, 16'h6008, 32'h300,      16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h301,      16'h3333,16'h0,   32'h301,     1));
        vecs.push_back(mk(1'b1, 1, 32'hFFFFFFFF, 0, 32'h0,  0,   0, 16'h0,    32'hFFFFFFFF, 16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h0,        16'h4444,16'h0,   32'h0,       1));
        vecs.push_back(mk(1'b1, 1, 32'h10,       0, 32'h0,  0,   0, 16'h0,    32'h10,       16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h11,       16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b0, 1, 32'h777,      1, 32'h7,  0,   0, 16'h0,    32'h0,        16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h1234,     16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h1234,     16'h0,   16'h0,   32'h0,       0));
        vecs.push_back(mk(1'b1, 0, 32'h0,        0, 32'h0,  0,   0, 16'h0,    32'h1235,     16'h0C00,16'h0,   32'h1235,    1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].chg, vecs[i].tgt, vecs[i].br, vecs[i].btgt,
                  vecs[i].haz, vecs[i].inj_s, vecs[i].inj);
            @(posedge clk); #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_imm,
                    vecs[i].e_ifpc, vecs[i].e_valid);
        end

        // Hazard stall between the two words must keep the first word latched.
        @(negedge clk); drive(1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        @(posedge clk); #1; chk_out("imm_stall redirect", 32'h500, 16'h0, 16'h0, 32'h0, 1'b0);
        @(negedge clk); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        @(posedge clk); #1; chk_out("imm_stall word1", 32'h501, 16'h0, 16'h0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
            @(posedge clk); #1;
            chk_out($sformatf("imm_stall hold%0d", k), 32'h501, 16'h0, 16'h0, 32'h0, 1'b0);
        end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        @(posedge clk); #1; chk_out("imm_stall word2", 32'h502, 16'hA123, 16'h7777, 32'h502, 1'b1);

        // Random run against the model.
        for (int a = 0; a < 4096; a++) begin
            if ($urandom_range(0, 3) == 0) mem[a] = 16'hA000 | 16'($urandom_range(0, 16'h1FFF));
            else                           mem[a] = 16'($urandom);
        end
        for (int a = 20'hFFFF0; a < (1 << c_addr_w); a++) mem[a] = 16'($urandom);
        mem[0] = 16'($urandom_range(0, 4095));
        mem[1] = 16'h0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset         = (cyc < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            change_pc     = ($urandom_range(0, 99) < 5);
            target_pc     = pick_target();
            branch_taken  = ($urandom_range(0, 99) < 8);
            branch_target = pick_target();
            hazard_stall  = ($urandom_range(0, 99) < 15);
            inject_stall  = ($urandom_range(0, 99) < 20);
            sel = $urandom_range(0, 3);
            inject_instr  = (sel == 0) ? 16'h0 : (sel == 1) ? 16'h6008 :
                            (sel == 2) ? 16'h6009 : 16'($urandom);
            if (m_known) begin
                exp_addr = (m_loads == 2) ? 32'd0 : (m_loads == 1) ? 32'd1 :
                           {12'h0, m_pc[c_addr_w-1:0]};
                chk($sformatf("rnd%0d imem_addr", cyc), {12'h0, bus.imem_addr}, exp_addr);
            end
            model_step();
            @(posedge clk); #1;
            chk_out($sformatf("rnd%0d", cyc), m_pc, m_instr, m_imm, m_ifpc, m_valid);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
